// File: rtl/slab_interval_reduce.sv
// Ray-AABB slab reduction: max of per-axis entry and min of per-axis exit over NAXES axes, then hit/miss.
// Optional build macro SLAB_CLIP_ORIGIN_EN clamps the first entry to +0 so hits behind the origin are clipped.
module slab_interval_reduce #(
  parameter int WE    = 11,
  parameter int WF    = 20,
  parameter int NAXES = 3,
  localparam int W    = WE + WF + 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] t_near,
  input  logic [W-1:0] t_far,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         hit,
  output logic [W-1:0] t_entry,
  output logic [W-1:0] t_exit,
  output logic         nan_seen
);

  localparam int CW = $clog2(NAXES + 1);
  localparam logic [W-1:0] POS_ZERO = '0;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] axis_cnt;

  function automatic logic is_nan(input logic [W-1:0] v);
    return v[W-1:W-2] == 2'b11;
  endfunction

  function automatic logic is_neg(input logic [W-1:0] v);
    return v[W-3] && (v[W-1:W-2] != 2'b00);
  endfunction

  // Signed total-order key: class {zero, normal, inf} above {exp, frac}, negated by the sign bit,
  // so -0 and +0 both map to key 0.
  function automatic logic signed [W-1:0] key_of(input logic [W-1:0] v);
    logic [W-2:0]          mag;
    logic signed [W-1:0]   pos;
    case (v[W-1:W-2])
      2'b00:   mag = '0;
      2'b01:   mag = {2'b01, v[WE+WF-1:0]};
      default: mag = {2'b10, {(WE+WF){1'b0}}};
    endcase
    pos = $signed({1'b0, mag});
    return v[W-3] ? -pos : pos;
  endfunction

  function automatic logic lt(input logic [W-1:0] a, input logic [W-1:0] b);
    return key_of(a) < key_of(b);
  endfunction

  logic         first;
  logic         accept;
  logic         last;
  logic [W-1:0] near_eff;
  logic [W-1:0] entry_nxt;
  logic [W-1:0] exit_nxt;
  logic         nan_nxt;
  logic         hit_nxt;

  always_comb begin
    first    = (state == IDLE);
    accept   = in_valid & in_ready;
    near_eff = t_near;
`ifdef SLAB_CLIP_ORIGIN_EN
    if (first && !lt(POS_ZERO, t_near)) near_eff = POS_ZERO;
`endif
    // Ties keep the stored operand; NaN operands never replace a stored bound.
    entry_nxt = t_entry;
    if (!is_nan(t_near) && (first || lt(t_entry, near_eff))) entry_nxt = near_eff;
    exit_nxt = t_exit;
    if (!is_nan(t_far) && (first || lt(t_far, t_exit))) exit_nxt = t_far;
    nan_nxt = (nan_seen & ~first) | is_nan(t_near) | is_nan(t_far);
    last    = first ? (NAXES == 1) : (axis_cnt == CW'(NAXES - 1));
    hit_nxt = lt(entry_nxt, exit_nxt) & ~is_neg(exit_nxt) & ~nan_nxt;
  end

  // Accumulate stage: entry/exit registers double as the held result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      axis_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      hit       <= 1'b0;
      nan_seen  <= 1'b0;
      t_entry   <= '0;
      t_exit    <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            t_entry  <= entry_nxt;
            t_exit   <= exit_nxt;
            nan_seen <= nan_nxt;
            axis_cnt <= first ? CW'(1) : axis_cnt + CW'(1);
            if (last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              hit       <= hit_nxt;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            axis_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            hit       <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          axis_cnt  <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          hit       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slab_interval_reduce.sv
// Bench for slab_interval_reduce: directed vector table, handshake corner sequences, and random rays
// checked against a real-valued ordering model.
module tb_slab_interval_reduce;

  localparam int W = 34;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] t_near;
  logic [W-1:0] t_far;
  logic         out_valid;
  logic         out_ready;
  logic         hit;
  logic [W-1:0] t_entry;
  logic [W-1:0] t_exit;
  logic         nan_seen;

  slab_interval_reduce #(.WE(11), .WF(20), .NAXES(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .t_near(t_near), .t_far(t_far),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .t_entry(t_entry), .t_exit(t_exit), .nan_seen(nan_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [W-1:0] ZERO = 34'h0_0000_0000;
  localparam logic [W-1:0] NZERO = 34'h0_8000_0000;
  localparam logic [W-1:0] ONE  = 34'h1_3FF0_0000;
  localparam logic [W-1:0] HALF = 34'h1_3FE0_0000;
  localparam logic [W-1:0] TWO  = 34'h1_4000_0000;
  localparam logic [W-1:0] THREE = 34'h1_4008_0000;
  localparam logic [W-1:0] NONE = 34'h1_BFF0_0000;
  localparam logic [W-1:0] NTHREE = 34'h1_C008_0000;
  localparam logic [W-1:0] PINF = 34'h2_0000_0000;
  localparam logic [W-1:0] NINF = 34'h2_8000_0000;
  localparam logic [W-1:0] QNAN = 34'h3_0000_0000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Reference ordering: magnitude as a real (zero=0, normal=1+exp+frac/2^20, inf=1e6), sign negates.
  function automatic real val(input logic [W-1:0] v);
    real m;
    case (v[33:32])
      2'b00:   m = 0.0;
      2'b01:   m = 1.0 + real'(v[30:20]) + real'(v[19:0]) / 1048576.0;
      default: m = 1.0e6;
    endcase
    return v[31] ? -m : m;
  endfunction

  function automatic bit isnan(input logic [W-1:0] v);
    return v[33:32] == 2'b11;
  endfunction

  logic [W-1:0] m_entry = '0;
  logic [W-1:0] m_exit  = '0;
  bit           m_nan;
  bit           m_hit;

  task automatic model_ray(input logic [2:0][W-1:0] n, input logic [2:0][W-1:0] f);
    m_nan = 0;
    for (int a = 0; a < 3; a++) begin
      if (!isnan(n[a])) begin
        if (a == 0) begin
          m_entry = n[a];
`ifdef SLAB_CLIP_ORIGIN_EN
          if (!(val(n[a]) > 0.0)) m_entry = ZERO;
`endif
        end else if (val(n[a]) > val(m_entry)) begin
          m_entry = n[a];
        end
      end
      if (!isnan(f[a]) && (a == 0 || val(f[a]) < val(m_exit))) m_exit = f[a];
      m_nan = m_nan | isnan(n[a]) | isnan(f[a]);
    end
    m_hit = (val(m_entry) < val(m_exit)) && !(m_exit[31] && m_exit[33:32] != 2'b00) && !m_nan;
  endtask

  task automatic send_pair(input logic [W-1:0] nn, input logic [W-1:0] ff, input int gap);
    int budget;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    t_near = nn;
    t_far  = ff;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 50) begin @(posedge clk); #1; budget++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Feeds three pairs; checks that out_valid is low until the third accept and high right after.
  task automatic feed_ray(input string nm, input logic [2:0][W-1:0] n, input logic [2:0][W-1:0] f,
                          input int gmax);
    for (int a = 0; a < 3; a++) begin
      send_pair(n[a], f[a], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
      if (a < 2) check({nm, ".valid_early"}, 64'(out_valid), 64'd0);
    end
    check({nm, ".valid"}, 64'(out_valid), 64'd1);
    model_ray(n, f);
  endtask

  task automatic release_ray(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, ".valid_drop"}, 64'(out_valid), 64'd0);
    check({nm, ".ready_back"}, 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    string              name;
    logic [2:0][W-1:0]  n;
    logic [2:0][W-1:0]  f;
    logic               hit;
    logic               nan;
    logic [W-1:0]       ent;
    logic [W-1:0]       ext;
  } vec_t;

  function automatic vec_t mkv(input string nm,
                               input logic [W-1:0] n0, n1, n2, f0, f1, f2,
                               input logic h, nn, input logic [W-1:0] e, x);
    vec_t v;
    v.name = nm;
    v.n[0] = n0; v.n[1] = n1; v.n[2] = n2;
    v.f[0] = f0; v.f[1] = f1; v.f[2] = f2;
    v.hit = h; v.nan = nn; v.ent = e; v.ext = x;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    int r;
    r = int'($urandom_range(0, 31));
    v = '0;
    v[31] = ($urandom_range(0, 3) == 0);
    if (r == 0) v[33:32] = 2'b00;
    else if (r == 1) v[33:32] = 2'b10;
    else if (r == 2) v[33:32] = 2'b11;
    else begin
      v[33:32] = 2'b01;
      v[30:20] = 11'(1020 + $urandom_range(0, 6));
      v[19:18] = 2'($urandom_range(0, 3));
    end
    return v;
  endfunction

  vec_t vt[8];
  logic [2:0][W-1:0] rn, rf;
  logic [W-1:0] clip_ent;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; t_near = '0; t_far = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.hit", 64'(hit), 64'd0);
    check("rst.nan_seen", 64'(nan_seen), 64'd0);
    check("rst.t_entry", 64'(t_entry), 64'd0);
    check("rst.t_exit", 64'(t_exit), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);

`ifdef SLAB_CLIP_ORIGIN_EN
    clip_ent = ZERO;
`else
    clip_ent = NTHREE;
`endif
    vt[0] = mkv("hit", ONE, HALF, ZERO, THREE, TWO, THREE, 1, 0, ONE, TWO);
    vt[1] = mkv("miss", TWO, HALF, ZERO, THREE, ONE, THREE, 0, 0, TWO, ONE);
    vt[2] = mkv("equal", ONE, HALF, ZERO, ONE, TWO, THREE, 0, 0, ONE, ONE);
    vt[3] = mkv("negexit", NTHREE, NTHREE, NTHREE, NONE, NONE, NONE, 0, 0, clip_ent, NONE);
    vt[4] = mkv("nan", ONE, HALF, ZERO, THREE, TWO, QNAN, 0, 1, ONE, TWO);
    vt[5] = mkv("inf", HALF, ONE, ZERO, PINF, THREE, PINF, 1, 0, ONE, THREE);
    vt[6] = mkv("negzero", ZERO, ZERO, ZERO, NZERO, ZERO, NZERO, 0, 0, ZERO, NZERO);
    vt[7] = mkv("ninf", NINF, 34'h1_3FF8_0000, 34'h1_3FF4_0000,
                34'h1_4004_0000, THREE, PINF, 1, 0, 34'h1_3FF8_0000, 34'h1_4004_0000);

    foreach (vt[i]) begin
      feed_ray(vt[i].name, vt[i].n, vt[i].f, 0);
      check({vt[i].name, ".hit"}, 64'(hit), 64'(vt[i].hit));
      check({vt[i].name, ".nan_seen"}, 64'(nan_seen), 64'(vt[i].nan));
      check({vt[i].name, ".t_entry"}, 64'(t_entry), 64'(vt[i].ent));
      check({vt[i].name, ".t_exit"}, 64'(t_exit), 64'(vt[i].ext));
      release_ray(vt[i].name);
    end

    // Backpressure: result held five cycles with in_ready low.
    rn[0] = ONE; rn[1] = HALF; rn[2] = ZERO;
    rf[0] = THREE; rf[1] = TWO; rf[2] = THREE;
    feed_ray("bp", rn, rf, 0);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp.in_ready", 64'(in_ready), 64'd0);
      check("bp.out_valid", 64'(out_valid), 64'd1);
      check("bp.hit", 64'(hit), 64'(m_hit));
      check("bp.t_entry", 64'(t_entry), 64'(m_entry));
      check("bp.t_exit", 64'(t_exit), 64'(m_exit));
    end
    release_ray("bp");

    // Asynchronous reset after two accepts, then a fresh ray.
    send_pair(TWO, THREE, 0);
    send_pair(ONE, PINF, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.t_entry", 64'(t_entry), 64'd0);
    check("midrst.t_exit", 64'(t_exit), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_entry = '0; m_exit = '0;
    rn[0] = HALF; rn[1] = ZERO; rn[2] = ONE;
    rf[0] = TWO; rf[1] = THREE; rf[2] = TWO;
    feed_ray("midrst", rn, rf, 0);
    check("midrst.hit", 64'(hit), 64'd1);
    check("midrst.t_entry", 64'(t_entry), 64'(ONE));
    check("midrst.t_exit", 64'(t_exit), 64'(TWO));
    release_ray("midrst");

    // Random rays with input stalls and output backpressure.
    for (int r = 0; r < 80; r++) begin
      for (int a = 0; a < 3; a++) begin
        rn[a] = rand_op();
        rf[a] = rand_op();
      end
      feed_ray("rnd", rn, rf, 2);
      check("rnd.hit", 64'(hit), 64'(m_hit));
      check("rnd.nan_seen", 64'(nan_seen), 64'(m_nan));
      check("rnd.t_entry", 64'(t_entry), 64'(m_entry));
      check("rnd.t_exit", 64'(t_exit), 64'(m_exit));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("rnd.hold_valid", 64'(out_valid), 64'd1);
        check("rnd.hold_hit", 64'(hit), 64'(m_hit));
      end
      release_ray("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
